// File: rtl/osd_wr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : osd_wr_sequencer
// Purpose  : Turns a queued command stream into OSD text/color RAM write
//            pulses and the OSD info word. It includes a write cursor and a
//            hardware clear-screen sweep.
// Option   : OSD_CURSOR_AUTOINC_EN - each WRITE advances the cursor
// Revision : 1.0 - initial release
// ============================================================================
module osd_wr_sequencer #(
  parameter int MAX_COLS   = 48,
  parameter int MAX_ROWS   = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        OSDCLK,
  input  logic        OSDRST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [14:0] cmd_data,
  output logic        busy,
  output logic [24:0] OSDWrVector,
  output logic [1:0]  OSDInfo
);

  localparam int          C_AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [C_AW-1:0] C_PTR_LAST = C_AW'(FIFO_DEPTH - 1);
  localparam logic [C_AW:0]   C_FULL     = (C_AW + 1)'(FIFO_DEPTH);
  localparam logic [5:0]  C_LAST_COL  = 6'(MAX_COLS - 1);
  localparam logic [3:0]  C_LAST_ROW  = 4'(MAX_ROWS - 1);
  localparam logic [9:0]  C_LAST_ADDR = {C_LAST_COL, C_LAST_ROW};
  localparam logic [1:0]  C_OP_CURSOR = 2'd0;
  localparam logic [1:0]  C_OP_WRITE  = 2'd1;
  localparam logic [1:0]  C_OP_INFO   = 2'd2;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  logic [16:0]     r_fifo_mem [FIFO_DEPTH];
  logic [C_AW-1:0] r_wr_ptr;
  logic [C_AW-1:0] r_rd_ptr;
  logic [C_AW:0]   r_count;
  logic [9:0]      r_cursor;
  logic [9:0]      r_clr_addr;
  logic [12:0]     r_fill;
  logic [1:0]      r_wrctrl;
  logic [9:0]      r_addr;
  logic [12:0]     r_wdata;
  logic [1:0]      r_info;

  logic            w_push;
  logic            w_pop;
  logic [16:0]     w_head;
  logic [1:0]      w_op;
  logic [14:0]     w_data;

  assign cmd_ready   = (r_count != C_FULL);
  assign busy        = (r_count != '0) | (r_state == S_CLEAR);
  assign w_push      = cmd_valid & cmd_ready;
  assign w_pop       = (r_state == S_IDLE) & (r_count != '0);
  assign w_head      = r_fifo_mem[r_rd_ptr];
  assign w_op        = w_head[16:15];
  assign w_data      = w_head[14:0];
  assign OSDWrVector = {r_wrctrl, r_addr, r_wdata};
  assign OSDInfo     = r_info;

  // Any position outside the visible grid restarts from the top-left cell.
  function automatic logic [9:0] f_cursor_inc(input logic [9:0] cur);
    if (cur[9:4] > C_LAST_COL || cur[3:0] > C_LAST_ROW) return 10'h000;
    if (cur[9:4] != C_LAST_COL) return {cur[9:4] + 6'd1, cur[3:0]};
    if (cur[3:0] != C_LAST_ROW) return {6'd0, cur[3:0] + 4'd1};
    return 10'h000;
  endfunction

  // Clear sweep walks rows first, then steps to the next column.
  function automatic logic [9:0] f_sweep_next(input logic [9:0] a);
    if (a[3:0] != C_LAST_ROW) return {a[9:4], a[3:0] + 4'd1};
    return {a[9:4] + 6'd1, 4'd0};
  endfunction

  always_ff @(posedge OSDCLK) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {cmd_op, cmd_data};
  end

  always_ff @(posedge OSDCLK) begin
    if (OSDRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge OSDCLK) begin
    if (OSDRST) begin
      r_state    <= S_IDLE;
      r_cursor   <= 10'h000;
      r_clr_addr <= 10'h000;
      r_fill     <= 13'h0000;
      r_wrctrl   <= 2'b00;
      r_addr     <= 10'h000;
      r_wdata    <= 13'h0000;
      r_info     <= 2'b00;
    end else begin
      r_wrctrl <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            case (w_op)
              C_OP_CURSOR: r_cursor <= w_data[9:0];
              C_OP_WRITE: begin
                if (w_data[14:13] != 2'b00) begin
                  r_wrctrl <= w_data[14:13];
                  r_addr   <= r_cursor;
                  r_wdata  <= w_data[12:0];
                end
`ifdef OSD_CURSOR_AUTOINC_EN
                r_cursor <= f_cursor_inc(r_cursor);
`else
`endif
              end
              C_OP_INFO: r_info <= w_data[1:0];
              default: begin
                r_wrctrl <= 2'b11;
                r_addr   <= 10'h000;
                r_wdata  <= w_data[12:0];
                r_fill   <= w_data[12:0];
                // A one-cell screen is finished by the pop-edge write alone.
                if (C_LAST_ADDR == 10'h000) begin
                  r_cursor <= 10'h000;
                end else begin
                  r_state    <= S_CLEAR;
                  r_clr_addr <= f_sweep_next(10'h000);
                end
              end
            endcase
          end
        end
        S_CLEAR: begin
          r_wrctrl   <= 2'b11;
          r_addr     <= r_clr_addr;
          r_wdata    <= r_fill;
          r_clr_addr <= f_sweep_next(r_clr_addr);
          if (r_clr_addr == C_LAST_ADDR) begin
            r_state  <= S_IDLE;
            r_cursor <= 10'h000;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_osd_wr_sequencer.sv
`default_nettype none
// Directed testbench for osd_wr_sequencer: vector table plus hand-written
// sequences for clear sweep, back-pressure and mid-clear reset.
module tb_osd_wr_sequencer;

`ifdef OSD_CURSOR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int NV = 12;

  logic        OSDCLK = 1'b0;
  logic        OSDRST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [14:0] cmd_data;
  logic        busy;
  logic [24:0] OSDWrVector;
  logic [1:0]  OSDInfo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [14:0] data;
    logic [24:0] exp_vec;
    logic [1:0]  exp_info;
  } vec_t;

  vec_t tbl [NV];

  osd_wr_sequencer dut (
    .OSDCLK      (OSDCLK),
    .OSDRST      (OSDRST),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .busy        (busy),
    .OSDWrVector (OSDWrVector),
    .OSDInfo     (OSDInfo)
  );

  always #5 OSDCLK = ~OSDCLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge OSDCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [14:0] d);
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [9:0]  a_b, a_6, a_10, exp_a, a1, a12, a13, alast;
    logic [1:0]  wc;
    int n, bad, first_c, mrow, mcol, wi, nw, n11;
    bit acc, full_chk_done;

    a_b  = AUTOINC ? 10'h0B3 : 10'h0A3;
    a_6  = AUTOINC ? 10'h000 : 10'h2FB;
    a_10 = AUTOINC ? 10'h010 : 10'h3FF;
    tbl[0]  = '{2'd0, 15'h00A3, {2'b00, 10'h000, 13'h0000}, 2'b00};
    tbl[1]  = '{2'd1, 15'h6041, {2'b11, 10'h0A3, 13'h0041}, 2'b00};
    tbl[2]  = '{2'd1, 15'h2007, {2'b01, a_b,     13'h0007}, 2'b00};
    tbl[3]  = '{2'd2, 15'h0003, {2'b00, a_b,     13'h0007}, 2'b11};
    tbl[4]  = '{2'd0, 15'h02FB, {2'b00, a_b,     13'h0007}, 2'b11};
    tbl[5]  = '{2'd1, 15'h2123, {2'b01, 10'h2FB, 13'h0123}, 2'b11};
    tbl[6]  = '{2'd1, 15'h4ABC, {2'b10, a_6,     13'h0ABC}, 2'b11};
    tbl[7]  = '{2'd0, 15'h03FF, {2'b00, a_6,     13'h0ABC}, 2'b11};
    tbl[8]  = '{2'd1, 15'h6001, {2'b11, 10'h3FF, 13'h0001}, 2'b11};
    tbl[9]  = '{2'd1, 15'h0055, {2'b00, 10'h3FF, 13'h0001}, 2'b11};
    tbl[10] = '{2'd1, 15'h2000, {2'b01, a_10,    13'h0000}, 2'b11};
    tbl[11] = '{2'd2, 15'h0002, {2'b00, a_10,    13'h0000}, 2'b10};

    OSDRST = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 15'h0;
    tick(); tick();
    OSDRST = 1'b0;
    tick();
    chk("reset_vec", OSDWrVector, 25'h0);
    chk("reset_info", OSDInfo, 2'b00);
    chk("reset_ready", cmd_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);

    // Single commands: effect lands on the edge after acceptance.
    for (int i = 0; i < NV; i++) begin
      send(tbl[i].op, tbl[i].data);
      chk($sformatf("v%0d_busy_queued", i), busy, 1'b1);
      chk($sformatf("v%0d_no_early_pulse", i), OSDWrVector[24:23], 2'b00);
      tick();
      chk($sformatf("v%0d_vec", i), OSDWrVector, tbl[i].exp_vec);
      chk($sformatf("v%0d_info", i), OSDInfo, tbl[i].exp_info);
      chk($sformatf("v%0d_busy_idle", i), busy, 1'b0);
      tick();
      chk($sformatf("v%0d_pulse_end", i), OSDWrVector, {2'b00, tbl[i].exp_vec[22:0]});
    end

    // Cursor wrap at the last cell and at the end of a row.
    send(2'd0, 15'h02FB); tick();
    send(2'd1, 15'h6001); tick();
    chk("wrap_last_cell_w1", OSDWrVector, {2'b11, 10'h2FB, 13'h0001});
    send(2'd1, 15'h2002); tick();
    chk("wrap_last_cell_w2", OSDWrVector, {2'b01, AUTOINC ? 10'h000 : 10'h2FB, 13'h0002});
    send(2'd0, 15'h02F3); tick();
    send(2'd1, 15'h6003); tick();
    chk("wrap_row_w1", OSDWrVector, {2'b11, 10'h2F3, 13'h0003});
    send(2'd1, 15'h2004); tick();
    chk("wrap_row_w2", OSDWrVector, {2'b01, AUTOINC ? 10'h004 : 10'h2F3, 13'h0004});
    tick();

    // Full clear sweep.
    send(2'd3, 15'h0E20);
    chk("clr_no_pulse_at_accept", OSDWrVector[24:23], 2'b00);
    n = 0; bad = 0; first_c = -1; mrow = 0; mcol = 0;
    a1 = '0; a12 = '0; a13 = '0; alast = '0;
    for (int c = 0; c < 700; c++) begin
      tick();
      if (OSDWrVector[24:23] == 2'b11) begin
        if (n == 0) first_c = c;
        n++;
        exp_a = {6'(mcol), 4'(mrow)};
        if (OSDWrVector[22:0] !== {exp_a, 13'h0E20}) bad++;
        if (n < 576 && busy !== 1'b1) bad++;
        if (n == 1)   a1    = OSDWrVector[22:13];
        if (n == 12)  a12   = OSDWrVector[22:13];
        if (n == 13)  a13   = OSDWrVector[22:13];
        if (n == 576) alast = OSDWrVector[22:13];
        mrow++;
        if (mrow == 12) begin mrow = 0; mcol++; end
      end else if (n > 0) begin
        break;
      end
    end
    chk("clr_first_latency", first_c, 0);
    chk("clr_count", n, 576);
    chk("clr_bad_pulses", bad, 0);
    chk("clr_addr_1", a1, 10'h000);
    chk("clr_addr_12", a12, 10'h00B);
    chk("clr_addr_13", a13, 10'h010);
    chk("clr_addr_last", alast, 10'h2FB);
    chk("clr_busy_after", busy, 1'b0);
    send(2'd1, 15'h2111); tick();
    chk("clr_cursor_zero", OSDWrVector, {2'b01, 10'h000, 13'h0111});
    tick();

    // Back-pressure: queue writes while a clear runs.
    send(2'd3, 15'h0000);
    wi = 0; nw = 0; n11 = 0; bad = 0; first_c = -1; full_chk_done = 1'b0;
    cmd_op = 2'd1; cmd_data = 15'h2001; cmd_valid = 1'b1;
    for (int c = 0; c < 800 && nw < 6; c++) begin
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) begin
        wi++;
        if (wi < 6) cmd_data = 15'h2000 | 15'(wi + 1);
        else cmd_valid = 1'b0;
      end
      if (wi == 4 && !full_chk_done) begin
        chk("q_ready_low_when_full", cmd_ready, 1'b0);
        full_chk_done = 1'b1;
      end
      wc = OSDWrVector[24:23];
      if (wc == 2'b11) begin
        n11++;
        if (nw > 0) bad++;
      end else if (wc == 2'b01) begin
        if (nw == 0) begin
          chk("q_clear_done_first", n11, 576);
          chk("q_accepted_before_drain", wi, 4);
          first_c = c;
        end
        chk($sformatf("q_w%0d_data", nw), OSDWrVector[12:0], 13'(nw + 1));
        chk($sformatf("q_w%0d_addr", nw), OSDWrVector[22:13], AUTOINC ? 10'(nw << 4) : 10'h000);
        if (c != first_c + nw) bad++;
        nw++;
      end else if (wc != 2'b00) begin
        bad++;
      end
    end
    cmd_valid = 1'b0;
    chk("q_write_count", nw, 6);
    chk("q_bad_or_gap", bad, 0);
    tick();
    chk("q_busy_drained", busy, 1'b0);

    // Reset at the 100th clear pulse, with a write queued behind the clear.
    send(2'd3, 15'h1555);
    cmd_op = 2'd1; cmd_data = 15'h6123; cmd_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 300 && n < 100; c++) begin
      tick();
      cmd_valid = 1'b0;
      if (OSDWrVector[24:23] == 2'b11) n++;
    end
    chk("rst_reached_100", n, 100);
    chk("rst_queue_nonempty", busy, 1'b1);
    OSDRST = 1'b1;
    tick();
    chk("rst_edge_vec", OSDWrVector, 25'h0);
    chk("rst_edge_info", OSDInfo, 2'b00);
    chk("rst_edge_busy", busy, 1'b0);
    OSDRST = 1'b0;
    tick();
    chk("rst_after_vec", OSDWrVector, 25'h0);
    chk("rst_after_busy", busy, 1'b0);
    chk("rst_after_ready", cmd_ready, 1'b1);
    tick();
    chk("rst_no_flushed_pop", OSDWrVector, 25'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
